// File: rtl/gemm_result_writer.sv
// Drains a C tile from NUM_ACC accumulator buffers to memory, row by row, one beat per buffer.
// Latency: 4 cycles per beat minimum (WAIT, POP, HOLD, WRITE); done pulses 1 cycle after the last transfer.
// Backpressure: mem_ready low holds WRITE with stable addr/data/strb; an empty buffer holds WAIT.
module gemm_result_writer #(
  parameter int NUM_ACC = 4,
  parameter int DATA_W  = 128,
  parameter int ELEM_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         tile_c_addr,
  input  logic [ADDR_W-1:0]         c_stride,
  input  logic [DIM_W-1:0]          msize,
  input  logic [DIM_W-1:0]          nsize,
  input  logic [NUM_ACC-1:0]        acc_empty,
  output logic [NUM_ACC-1:0]        acc_rd_en,
  input  logic [NUM_ACC*DATA_W-1:0] acc_rd_data,
  output logic                      mem_en,
  output logic                      mem_rdwr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic [DATA_W/8-1:0]       mem_wstrb,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int EPB    = DATA_W / ELEM_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int ELEM_B = ELEM_W / 8;
  localparam int BW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  localparam logic [DIM_W:0] EPB_V    = (DIM_W+1)'(EPB);
  localparam logic [DIM_W:0] EPB_M1_V = (DIM_W+1)'(EPB - 1);
  localparam logic [DIM_W:0] NACC_V   = (DIM_W+1)'(NUM_ACC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_HOLD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched tile configuration and walk position
  logic [DIM_W-1:0]  msize_q;
  logic [DIM_W-1:0]  row_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     nb_m1_q;
  logic              partial_q;
  logic [STRB_W-1:0] last_strb_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [DATA_W-1:0] data_q;
  logic              cfg_err_q;

  // Decoded configuration, only consumed when a start is accepted
  logic [DIM_W:0]    nsize_ext;
  logic [DIM_W:0]    nb_raw;
  logic [DIM_W:0]    rem;
  logic              clamp_c;
  logic              zero_c;
  logic              partial_c;
  logic [BW-1:0]     nb_m1_c;
  logic [STRB_W-1:0] last_strb_c;

  logic start_ok;
  logic xfer;
  logic last_beat;
  logic last_row;

  // Beats per row, clamp detection and the strobe mask of a short final beat
  always_comb begin
    nsize_ext = {1'b0, nsize};
    nb_raw    = (nsize_ext + EPB_M1_V) / EPB_V;
    rem       = nsize_ext % EPB_V;
    clamp_c   = (nb_raw > NACC_V);
    zero_c    = (msize == '0) || (nsize == '0);
    // A clamped row is cut short, so its last written beat is a full one
    partial_c = (rem != '0) && !clamp_c;
    nb_m1_c   = clamp_c ? BW'(NUM_ACC - 1) : BW'(nb_raw - 1'b1);
    for (int i = 0; i < STRB_W; i++) begin
      last_strb_c[i] = (i < int'(rem) * ELEM_B);
    end
  end

  assign start_ok  = (state_q == S_IDLE) && start;
  assign xfer      = (state_q == S_WRITE) && mem_ready;
  assign last_beat = (beat_q == nb_m1_q);
  assign last_row  = (row_q == msize_q - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore outputs; data-bearing outputs are zero outside WRITE
  always_comb begin
    state_d     = state_q;
    acc_rd_en   = '0;
    mem_en      = 1'b0;
    mem_rdwr    = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wstrb   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = zero_c ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (!acc_empty[beat_q]) state_d = S_POP;
      end
      S_POP: begin
        busy              = 1'b1;
        acc_rd_en[beat_q] = 1'b1;
        state_d           = S_HOLD;
      end
      S_HOLD: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_en      = 1'b1;
        mem_rdwr    = 1'b1;
        mem_addr    = row_base_q + ADDR_W'(beat_q) * ADDR_W'(STRB_W);
        mem_wr_data = data_q;
        mem_wstrb   = (last_beat && partial_q) ? last_strb_q : '1;
        if (mem_ready) state_d = (last_beat && last_row) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, beat capture and row/beat walk
  always_ff @(posedge clk) begin
    if (rst) begin
      msize_q     <= '0;
      row_q       <= '0;
      beat_q      <= '0;
      nb_m1_q     <= '0;
      partial_q   <= 1'b0;
      last_strb_q <= '0;
      row_base_q  <= '0;
      stride_q    <= '0;
      data_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        msize_q     <= msize;
        nb_m1_q     <= nb_m1_c;
        partial_q   <= partial_c;
        last_strb_q <= last_strb_c;
        row_base_q  <= tile_c_addr;
        stride_q    <= c_stride;
        row_q       <= '0;
        beat_q      <= '0;
        cfg_err_q   <= clamp_c;
      end
      if (state_q == S_HOLD) begin
        data_q <= acc_rd_data[int'(beat_q)*DATA_W +: DATA_W];
      end
      if (xfer) begin
        if (!last_beat) begin
          beat_q <= beat_q + 1'b1;
        end else if (!last_row) begin
          row_q      <= row_q + 1'b1;
          beat_q     <= '0;
          row_base_q <= row_base_q + stride_q;
        end
      end
    end
  end

  assign cfg_err = cfg_err_q;

endmodule
